mbus_arb: RTL

MBUS_ARB -- requirements
Module: mbus_arb

---
 rtl/mbus_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mbus_arb.sv
// mbus_arb: arbitrates one memory bus between a CPU and a DMA master.
// DMA bursts start only on instruction boundaries and are capped per grant.
module mbus_arb #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] cpu_aout,
    input  logic [WIDTH-1:0]     cpu_dout,
    input  logic                 cpu_wen,
    input  logic                 cpu_boundary,
    output logic [WIDTH-1:0]     cpu_din,
    output logic                 cpu_stall,
    input  logic                 dma_req,
    input  logic [ADDR_SIZE-1:0] dma_aout,
    input  logic [WIDTH-1:0]     dma_dout,
    input  logic                 dma_wen,
    output logic                 dma_gnt,
    output logic [WIDTH-1:0]     dma_rdata,
    output logic                 dma_rvalid,
    output logic [ADDR_SIZE-1:0] mbus_aout,
    output logic [WIDTH-1:0]     mbus_dout,
    output logic                 mbus_wen,
    input  logic [WIDTH-1:0]     mbus_din,
    output logic [15:0]          grant_count
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

    state_t           state_q;
    state_t           state_d;
    logic             hold_q;
    logic             hold_d;
    logic [7:0]       burst_q;
    logic [7:0]       burst_d;
    logic             rvalid_q;
    logic             rvalid_d;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
    logic [15:0]      gcnt_q;
    logic [15:0]      gcnt_d;
    logic             xfer;
    logic             enter;
    logic             leave;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant on an unheld boundary, release on idle or burst cap
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                if (dma_req && cpu_boundary && !hold_q) begin
                    state_d = S_DMA;
                end
            end
            S_DMA: begin
                if (!dma_req || (burst_q == LAST)) begin
                    state_d = S_CPU;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    // Output mux: bus ownership follows the registered state only
    always_comb begin
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        mbus_aout = cpu_aout;
        mbus_dout = cpu_dout;
        mbus_wen  = cpu_wen;
        if (state_q == S_DMA) begin
            dma_gnt   = 1'b1;
            cpu_stall = 1'b1;
            mbus_aout = dma_aout;
            mbus_dout = dma_dout;
            mbus_wen  = dma_req & dma_wen;
        end
    end

    assign cpu_din     = mbus_din;
    assign dma_rdata   = rdata_q;
    assign dma_rvalid  = rvalid_q;
    assign grant_count = gcnt_q;

    assign xfer  = (state_q == S_DMA) && dma_req;
    assign enter = (state_q == S_CPU) && (state_d == S_DMA);
    assign leave = (state_q == S_DMA) && (state_d == S_CPU);

    // Datapath next values: hold flag, burst count, read return, grant count
    always_comb begin
        hold_d = hold_q;
        if (leave) begin
            hold_d = 1'b1;
        end else if ((state_q == S_CPU) && cpu_boundary) begin
            hold_d = 1'b0;
        end

        burst_d = 8'd0;
        if (xfer && (state_d == S_DMA)) begin
            burst_d = burst_q + 8'd1;
        end

        rvalid_d = xfer && !dma_wen;
        rdata_d  = rdata_q;
        if (rvalid_d) begin
            rdata_d = mbus_din;
        end

        gcnt_d = gcnt_q;
        if (enter && (gcnt_q != 16'hFFFF)) begin
            gcnt_d = gcnt_q + 16'd1;
        end
    end

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q   <= 1'b0;
            burst_q  <= 8'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            gcnt_q   <= 16'd0;
        end else begin
            hold_q   <= hold_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            gcnt_q   <= gcnt_d;
        end
    end

endmodule
